// File: rtl/uart_tx_fifo_engine_if.sv
// Push/status handshake between the eUSCI register block (master) and the
// UART transmit FIFO engine (slave).
interface uart_tx_fifo_engine_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] TxData;
  logic              TxBufRdy;
  logic              TxBufClr;
  logic              TxOvr;
  logic              TxBEN;
  logic              TxFull;
  logic [LW-1:0]     TxLevel;
  logic              setTXIFG;
  logic              setTXCPTIFG;

  modport master (
    output TxData, TxBufRdy,
    input  TxBufClr, TxOvr, TxBEN, TxFull, TxLevel, setTXIFG, setTXCPTIFG
  );

  modport slave (
    input  TxData, TxBufRdy,
    output TxBufClr, TxOvr, TxBEN, TxFull, TxLevel, setTXIFG, setTXCPTIFG
  );
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: FIFO-fed serialiser with 7/8/9-bit data, parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the wUCTXBRK break-frame input.
module uart_tx_fifo_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 9
) (
  input  logic BITCLK,
  input  logic reset,
  input  logic wUCPEN,
  input  logic wUCPAR,
  input  logic wUCMSB,
  input  logic wUC7BIT,
  input  logic wUC9BIT,
  input  logic wUCSPB,
`ifdef UART_TX_BREAK_EN
  input  logic wUCTXBRK,
`endif
  uart_tx_fifo_engine_if.slave txIf,
  output logic TxBusy,
  output logic Tx
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} txState_t;
  txState_t state, stateNext;

  logic [DATA_W-1:0] fifoMem [FIFO_DEPTH];
  logic [AW-1:0]     rdPtr, wrPtr, rdPtrNext, wrPtrNext;
  logic [LW-1:0]     level;

  logic [8:0] shifter;
  logic [3:0] bitsLeft;
  logic       penL, spbL, parL;
  logic       clrQ, ovrQ, ifgQ, cptQ;

  logic              fifoEmpty, fifoFull, frameEnd, popReq, cutThru, load;
  logic              pushOk, pushDrop, frameDone, brkNow, parBit;
  logic [DATA_W-1:0] loadChar;
  logic [8:0]        charPad, charOrd, dataMask;
  logic [3:0]        dwSel;

`ifdef UART_TX_BREAK_EN
  assign brkNow = wUCTXBRK;
`else
  assign brkNow = 1'b0;
`endif

  assign fifoEmpty = (level == '0);
  assign fifoFull  = (level == FULL_LEVEL);
  assign frameEnd  = (state == STOP2) || (state == STOP1 && !spbL);
  assign popReq    = ((state == IDLE) || frameEnd) && !fifoEmpty;
  assign cutThru   = (state == IDLE) && fifoEmpty && txIf.TxBufRdy;
  assign load      = popReq || cutThru;
  assign pushOk    = txIf.TxBufRdy && !cutThru && (!fifoFull || popReq);
  assign pushDrop  = txIf.TxBufRdy && fifoFull && !popReq;
  assign frameDone = frameEnd && fifoEmpty;
  assign loadChar  = cutThru ? txIf.TxData : fifoMem[rdPtr];
  assign rdPtrNext = (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
  assign wrPtrNext = (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;

  // Character preparation at load: width select, parity, and bit reversal
  // for MSB-first so the shifter always emits bit 0 next.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    charPad = '0;
    charPad[DATA_W-1:0] = loadChar;
    if (wUC9BIT && DATA_W == 9) begin
      dwSel    = 4'd9;
      dataMask = 9'h1FF;
    end else if (wUC7BIT) begin
      dwSel    = 4'd7;
      dataMask = 9'h07F;
    end else begin
      dwSel    = 4'd8;
      dataMask = 9'h0FF;
    end
    charOrd = charPad & dataMask;
    parBit  = (^charOrd) ^ ~wUCPAR;
    if (wUCMSB) begin
      charOrd = '0;
      case (dwSel)
        4'd7:    for (int i = 0; i < 7; i++) charOrd[i] = charPad[6-i];
        4'd9:    for (int i = 0; i < 9; i++) charOrd[i] = charPad[8-i];
        default: for (int i = 0; i < 8; i++) charOrd[i] = charPad[7-i];
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load) stateNext = START;
      START:   stateNext = DATA;
      DATA:    if (bitsLeft == 4'd0) stateNext = penL ? PARITY : STOP1;
      PARITY:  stateNext = STOP1;
      STOP1:   stateNext = spbL ? STOP2 : (load ? START : IDLE);
      STOP2:   stateNext = load ? START : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge BITCLK) begin
    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge BITCLK) begin
    if (reset) begin
      Tx       <= 1'b1;
      shifter  <= '0;
      bitsLeft <= '0;
      penL     <= 1'b0;
      spbL     <= 1'b0;
      parL     <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      level    <= '0;
      clrQ     <= 1'b0;
      ovrQ     <= 1'b0;
      ifgQ     <= 1'b0;
      cptQ     <= 1'b0;
    end else begin
      clrQ <= pushOk || cutThru;
      ovrQ <= pushDrop;
      ifgQ <= load;
      cptQ <= frameDone;

      // A break is an all-zero 12-bit data phase after the start bit, one stop.
      if (load) begin
        shifter  <= brkNow ? 9'd0 : charOrd;
        bitsLeft <= brkNow ? 4'd11 : dwSel - 4'd1;
        penL     <= wUCPEN && !brkNow;
        spbL     <= wUCSPB && !brkNow;
        parL     <= parBit;
      end else if (stateNext == DATA) begin
        shifter <= shifter >> 1;
        if (state == DATA) bitsLeft <= bitsLeft - 4'd1;
      end

      case (stateNext)
        START:   Tx <= 1'b0;
        DATA:    Tx <= shifter[0];
        PARITY:  Tx <= parL;
        default: Tx <= 1'b1;
      endcase

      if (pushOk) wrPtr <= wrPtrNext;
      if (popReq) rdPtr <= rdPtrNext;
      case ({pushOk, popReq})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and level alone define validity.
  always_ff @(posedge BITCLK) begin
    if (pushOk) fifoMem[wrPtr] <= txIf.TxData;
  end

  assign TxBusy           = (state != IDLE);
  assign txIf.TxBEN       = fifoEmpty;
  assign txIf.TxFull      = fifoFull;
  assign txIf.TxLevel     = level;
  assign txIf.TxBufClr    = clrQ;
  assign txIf.TxOvr       = ovrQ;
  assign txIf.setTXIFG    = ifgQ;
  assign txIf.setTXCPTIFG = cptQ;
endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Directed bench for uart_tx_fifo_engine; outputs sampled on the falling BITCLK edge.
module tb_uart_tx_fifo_engine;
  localparam int DW = 9;
  localparam int FD = 4;

  logic BITCLK = 1'b0;
  logic reset  = 1'b1;
  logic wUCPEN = 1'b0, wUCPAR = 1'b0, wUCMSB = 1'b0;
  logic wUC7BIT = 1'b0, wUC9BIT = 1'b0, wUCSPB = 1'b0;
  logic brk = 1'b0;
  logic TxBusy, Tx;

  int nChecks = 0;
  int nFails  = 0;

  uart_tx_fifo_engine_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) txIf ();

  uart_tx_fifo_engine #(.FIFO_DEPTH(FD), .DATA_W(DW)) dut (
    .BITCLK  (BITCLK),
    .reset   (reset),
    .wUCPEN  (wUCPEN),
    .wUCPAR  (wUCPAR),
    .wUCMSB  (wUCMSB),
    .wUC7BIT (wUC7BIT),
    .wUC9BIT (wUC9BIT),
    .wUCSPB  (wUCSPB),
`ifdef UART_TX_BREAK_EN
    .wUCTXBRK(brk),
`endif
    .txIf    (txIf),
    .TxBusy  (TxBusy),
    .Tx      (Tx)
  );

  always #5 BITCLK = ~BITCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge BITCLK);
  endtask

  task automatic setCfg(input logic pen, par, msb, b7, b9, spb);
    wUCPEN = pen; wUCPAR = par; wUCMSB = msb;
    wUC7BIT = b7; wUC9BIT = b9; wUCSPB = spb;
  endtask

  // One push strobe; returns at the falling edge after the push edge.
  task automatic push(input logic [DW-1:0] d);
    txIf.TxData   = d;
    txIf.TxBufRdy = 1'b1;
    tick();
    txIf.TxBufRdy = 1'b0;
  endtask

  // Compare Tx against a '0'/'1' pattern, one character per BITCLK.
  task automatic expectLine(input string tag, input string pat, input int startIdx);
    for (int i = startIdx; i < pat.len(); i++) begin
      check($sformatf("%s bit%0d", tag, i), 32'(Tx), 32'(pat.getc(i) == "1"));
      check($sformatf("%s cpt%0d", tag, i), 32'(txIf.setTXCPTIFG), 32'd0);
      tick();
    end
  endtask

  initial begin
    txIf.TxData   = '0;
    txIf.TxBufRdy = 1'b0;
    tick();
    tick();
    check("rst Tx",     32'(Tx), 32'd1);
    check("rst TxBEN",  32'(txIf.TxBEN), 32'd1);
    check("rst TxFull", 32'(txIf.TxFull), 32'd0);
    check("rst TxLevel", 32'(txIf.TxLevel), 32'd0);
    check("rst TxBusy", 32'(TxBusy), 32'd0);
    check("rst pulses", 32'({txIf.setTXIFG, txIf.setTXCPTIFG, txIf.TxBufClr, txIf.TxOvr}), 32'd0);
    reset = 1'b0;
    tick();

    // 8N1 LSB-first, cut-through push of 0xA5
    setCfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(9'h0A5);
    check("8N1 ifg", 32'(txIf.setTXIFG), 32'd1);
    check("8N1 clr", 32'(txIf.TxBufClr), 32'd1);
    check("8N1 busy", 32'(TxBusy), 32'd1);
    check("8N1 fifo untouched", 32'(txIf.TxBEN), 32'd1);
    expectLine("8N1", "0101001011", 0);
    check("8N1 cpt", 32'(txIf.setTXCPTIFG), 32'd1);
    check("8N1 idle busy", 32'(TxBusy), 32'd0);
    tick();
    check("8N1 cpt one cycle", 32'(txIf.setTXCPTIFG), 32'd0);

    // 7O2 MSB-first, two frames back to back
    setCfg(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    push(9'h035);
    check("7O2 start", 32'(Tx), 32'd0);
    push(9'h024);
    check("7O2 level", 32'(txIf.TxLevel), 32'd1);
    check("7O2 clr queued", 32'(txIf.TxBufClr), 32'd1);
    check("7O2 ifg queued", 32'(txIf.setTXIFG), 32'd0);
    expectLine("7O2", "0011010111100100100111", 1);
    check("7O2 cpt", 32'(txIf.setTXCPTIFG), 32'd1);
    check("7O2 level end", 32'(txIf.TxLevel), 32'd0);

    // 9E1 LSB-first, 0x1FF
    setCfg(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(9'h1FF);
    expectLine("9E1", "011111111111", 0);
    check("9E1 cpt", 32'(txIf.setTXCPTIFG), 32'd1);

    // FIFO fill: six pushes, last one overflows
    setCfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      push(9'(k * 'h11));
      check($sformatf("fill%0d clr", k), 32'(txIf.TxBufClr), (k <= 5) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d ovr", k), 32'(txIf.TxOvr), (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d level", k), 32'(txIf.TxLevel), (k <= 5) ? 32'(k - 1) : 32'd4);
      check($sformatf("fill%0d full", k), 32'(txIf.TxFull), (k >= 5) ? 32'd1 : 32'd0);
    end
    expectLine("fill", {"0100010001", "0010001001", "0110011001", "0001000101", "0101010101"}, 5);
    check("fill cpt", 32'(txIf.setTXCPTIFG), 32'd1);
    check("fill empty", 32'(txIf.TxBEN), 32'd1);

    // Reset at data bit 4 with two characters queued
    push(9'h0A5);
    push(9'h001);
    push(9'h002);
    check("rstmid level", 32'(txIf.TxLevel), 32'd2);
    tick();
    tick();
    check("rstmid bit4", 32'(Tx), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid Tx", 32'(Tx), 32'd1);
    check("rstmid TxBEN", 32'(txIf.TxBEN), 32'd1);
    check("rstmid level0", 32'(txIf.TxLevel), 32'd0);
    check("rstmid busy", 32'(TxBusy), 32'd0);
    expectLine("rstmid idle", "1111111111111111", 0);
    check("rstmid still idle", 32'(TxBusy), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break frame: 13 low, 1 high stop
    brk = 1'b1;
    push(9'h055);
    brk = 1'b0;
    check("brk ifg", 32'(txIf.setTXIFG), 32'd1);
    expectLine("brk", "00000000000001", 0);
    check("brk cpt", 32'(txIf.setTXCPTIFG), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
